// File: rtl/mult_div_if.sv
// mult_div_if -- request/result bundle between the controller and the
// multiply/divide unit.
//
//   start   : launch the operation selected by md_op
//   md_op   : 00 mult, 01 multu, 10 div, 11 divu
//   a, b    : rs / rt operands
//   hi_we   : mthi, write wdata to HI
//   lo_we   : mtlo, write wdata to LO
//   wdata   : mthi/mtlo data
//   busy    : operation in flight, controller must stall
//   done    : one-cycle pulse after HI/LO commit
//   hi, lo  : architectural HI/LO registers
//
// master = controller side, slave = mult_div side.
interface mult_div_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div.sv
// mult_div -- multi-cycle multiply/divide unit holding the HI/LO registers.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-low; clears HI/LO and aborts any operation
//   bus    : mult_div_if.slave (start/md_op/a/b/hi_we/lo_we/wdata in,
//            busy/done/hi/lo out)
//
// Parameters:
//   MULT_CYCLES : cycles busy stays high for mult/multu (>= 1)
//   DIV_CYCLES  : cycles busy stays high for div/divu (>= 1)
//
// Build option:
//   MULT_DIV_DIV_EN : when defined, div/divu are implemented. When undefined
//                     there is no divider and a start with md_op = 1x is
//                     ignored entirely.
//
// The result is computed combinationally from the operands latched at start;
// the counter only sets when it is committed.
module mult_div #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  // Operands latched at start.
  logic [31:0]      a_p0;
  logic [31:0]      b_p0;
  logic             op_unsigned_p0;
`ifdef MULT_DIV_DIV_EN
  logic             op_div_p0;
`endif

  logic             accept;
  logic [CNT_W-1:0] load_cnt;
  logic [63:0]      result;

  // Low 64 bits of the product of the 64-bit extended operands equal the
  // true 64-bit product for both signed and unsigned flavours.
  function automatic logic [63:0] mul_result(input logic        is_unsigned,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
    logic signed [63:0] xe;
    logic signed [63:0] ye;
    xe = is_unsigned ? {32'b0, x} : {{32{x[31]}}, x};
    ye = is_unsigned ? {32'b0, y} : {{32{y[31]}}, y};
    return xe * ye;
  endfunction

`ifdef MULT_DIV_DIV_EN
  // Returns {remainder, quotient}. Divide-by-zero and the single signed
  // overflow case are pinned explicitly rather than left to the operator.
  function automatic logic [63:0] div_result(input logic        is_unsigned,
                                             input logic [31:0] n,
                                             input logic [31:0] d);
    logic signed [31:0] sn;
    logic signed [31:0] sd;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic        [31:0] uq;
    logic        [31:0] ur;
    if (d == 32'd0) begin
      return {n, 32'hFFFF_FFFF};
    end
    if (is_unsigned) begin
      uq = n / d;
      ur = n % d;
      return {ur, uq};
    end
    if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      return {32'h0000_0000, 32'h8000_0000};
    end
    sn = n;
    sd = d;
    sq = sn / sd;
    sr = sn % sd;
    return {sr, sq};
  endfunction
`endif

  always_comb begin
    accept = bus.start;
`ifdef MULT_DIV_DIV_EN
    load_cnt = bus.md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    result   = op_div_p0 ? div_result(op_unsigned_p0, a_p0, b_p0)
                         : mul_result(op_unsigned_p0, a_p0, b_p0);
`else
    accept   = bus.start & ~bus.md_op[1];
    load_cnt = CNT_W'(MULT_CYCLES);
    result   = mul_result(op_unsigned_p0, a_p0, b_p0);
`endif
  end

  // ---- p0: operand capture (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      a_p0           <= bus.a;
      b_p0           <= bus.b;
      op_unsigned_p0 <= bus.md_op[0];
`ifdef MULT_DIV_DIV_EN
      op_div_p0      <= bus.md_op[1];
`endif
    end
  end

  // ---- control FSM and HI/LO commit ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            // start wins over a same-edge mthi/mtlo
            state  <= RUN;
            cnt    <= load_cnt;
            busy_q <= 1'b1;
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            hi_q   <= result[63:32];
            lo_q   <= result[31:0];
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div -- directed bench for mult_div with default cycle counts.
// Expectations for div/divu follow MULT_DIV_DIV_EN: with it undefined a
// divide start must leave the unit idle and HI/LO untouched.
module tb_mult_div;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  mult_div_if mif ();

  mult_div #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Launch an operation, scramble the operand inputs while it runs, check
  // busy for n cycles, then the commit cycle and the single done pulse.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] x, input logic [31:0] y, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mif.start = 1'b1;
    mif.md_op = op;
    mif.a     = x;
    mif.b     = y;
    step();
    mif.start = 1'b0;
    mif.a     = 32'h5A5A_0F0F;
    mif.b     = 32'h0000_0000;
    for (int i = 0; i < n; i++) begin
      check({tag, " busy"}, 32'(mif.busy), 32'd1);
      check({tag, " done early"}, 32'(mif.done), 32'd0);
      step();
    end
    check({tag, " busy end"}, 32'(mif.busy), 32'd0);
    check({tag, " done"}, 32'(mif.done), 32'd1);
    check({tag, " hi"}, mif.hi, exp_hi);
    check({tag, " lo"}, mif.lo, exp_lo);
    step();
    check({tag, " done once"}, 32'(mif.done), 32'd0);
  endtask

  initial begin
    logic [1:0] abort_op;
    mif.start = 1'b0;
    mif.md_op = 2'b00;
    mif.a     = 32'd0;
    mif.b     = 32'd0;
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    mif.wdata = 32'd0;
    reset     = 1'b0;
    step();
    reset = 1'b1;

    // Arbitrary writes, then one reset edge clears everything.
    mif.hi_we = 1'b1;
    mif.lo_we = 1'b1;
    mif.wdata = 32'hDEAD_BEEF;
    step();
    check("pre-reset hi", mif.hi, 32'hDEAD_BEEF);
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    reset     = 1'b0;
    step();
    reset = 1'b1;
    check("reset hi", mif.hi, 32'd0);
    check("reset lo", mif.lo, 32'd0);
    check("reset busy", 32'(mif.busy), 32'd0);
    check("reset done", 32'(mif.done), 32'd0);

    // Multiply: signed and unsigned interpretations of the same operands.
    run_op("mult -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu -2*3", 2'b01, 32'hFFFF_FFFE, 32'd3, MC, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("mult -1*-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'h0000_0000, 32'h0000_0001);
    run_op("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h0000_0001);

`ifdef MULT_DIV_DIV_EN
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/0", 2'b11, 32'd7, 32'd0, DC, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0000_0000, 32'h8000_0000);
    run_op("div 7/0", 2'b10, 32'd7, 32'd0, DC, 32'h0000_0007, 32'hFFFF_FFFF);
    abort_op = 2'b10;
`else
    // No divider: div and divu starts are dropped, HI/LO keep the last result.
    mif.start = 1'b1;
    mif.md_op = 2'b10;
    mif.a     = 32'hFFFF_FFF9;
    mif.b     = 32'd2;
    step();
    mif.md_op = 2'b11;
    step();
    mif.start = 1'b0;
    for (int i = 0; i < DC + 2; i++) begin
      check("nodiv busy", 32'(mif.busy), 32'd0);
      check("nodiv done", 32'(mif.done), 32'd0);
      step();
    end
    check("nodiv hi", mif.hi, 32'hFFFF_FFFE);
    check("nodiv lo", mif.lo, 32'h0000_0001);
    abort_op = 2'b00;
`endif

    // start/mthi during RUN are ignored.
    mif.start = 1'b1;
    mif.md_op = 2'b00;
    mif.a     = 32'd2;
    mif.b     = 32'd3;
    step();
    mif.md_op = 2'b10;
    mif.hi_we = 1'b1;
    mif.wdata = 32'h0000_1234;
    step();
    mif.start = 1'b0;
    mif.hi_we = 1'b0;
    check("run ignore busy", 32'(mif.busy), 32'd1);
    for (int i = 0; i < MC - 1; i++) step();
    check("run ignore done", 32'(mif.done), 32'd1);
    check("run ignore hi", mif.hi, 32'h0000_0000);
    check("run ignore lo", mif.lo, 32'h0000_0006);
    step();
    check("run ignore idle", 32'(mif.busy), 32'd0);

    // Idle mthi+mtlo together.
    mif.hi_we = 1'b1;
    mif.lo_we = 1'b1;
    mif.wdata = 32'hA5A5_A5A5;
    step();
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    check("mthi", mif.hi, 32'hA5A5_A5A5);
    check("mtlo", mif.lo, 32'hA5A5_A5A5);

    // start and mthi/mtlo on the same edge: start wins.
    mif.hi_we = 1'b1;
    mif.lo_we = 1'b1;
    mif.wdata = 32'h1111_1111;
    mif.start = 1'b1;
    mif.md_op = 2'b00;
    mif.a     = 32'd4;
    mif.b     = 32'd5;
    step();
    mif.hi_we = 1'b0;
    mif.lo_we = 1'b0;
    mif.start = 1'b0;
    check("start wins busy", 32'(mif.busy), 32'd1);
    check("start wins hi", mif.hi, 32'hA5A5_A5A5);
    check("start wins lo", mif.lo, 32'hA5A5_A5A5);
    for (int i = 0; i < MC - 1; i++) step();
    check("start wins busy held", 32'(mif.busy), 32'd1);
    step();
    check("start wins res hi", mif.hi, 32'h0000_0000);
    check("start wins res lo", mif.lo, 32'h0000_0014);
    check("start wins done", 32'(mif.done), 32'd1);
    step();

    // Reset in the third cycle of an operation aborts it.
    mif.start = 1'b1;
    mif.md_op = abort_op;
    mif.a     = 32'd100;
    mif.b     = 32'd7;
    step();
    mif.start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort busy", 32'(mif.busy), 32'd0);
    check("abort done", 32'(mif.done), 32'd0);
    check("abort hi", mif.hi, 32'd0);
    check("abort lo", mif.lo, 32'd0);
    for (int i = 0; i < DC + 2; i++) begin
      check("abort no done", 32'(mif.done), 32'd0);
      step();
    end
    check("abort lo held", mif.lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_div.md
# mult_div

Multi-cycle multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. Sits downstream of `control` and the register file: consumes decoded mult/div/mthi/mtlo requests with two 32-bit register operands, and produces HI/LO for mfhi/mflo. A `busy` output tells the controller to stall dependent instructions while an operation is in flight.

## Interface

- `MULT_CYCLES`, default 5: cycles `busy` stays high for mult/multu (≥1).
- `DIV_CYCLES`, default 10: cycles `busy` stays high for div/divu (≥1).

- `clk` in 1: clock, rising edge.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `start` in 1: launch operation selected by `md_op`.
- `md_op` in 2: 00 mult, 01 multu, 10 div, 11 divu.
- `a` in 32: rs operand (multiplicand / dividend).
- `b` in 32: rt operand (multiplier / divisor).
- `hi_we` in 1: mthi, write `wdata` to HI.
- `lo_we` in 1: mtlo, write `wdata` to LO.
- `wdata` in 32: mthi/mtlo data.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse after results committed.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation

- States: IDLE, RUN. Reset (`reset`=0 at edge) forces IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- IDLE + `start`: latch `a`, `b`, `md_op`; load counter with `MULT_CYCLES` or `DIV_CYCLES`; go RUN.
- RUN: decrement counter each edge; when counter reaches 1 at an edge, commit result to HI/LO, go IDLE, pulse `done` next cycle.
- `start`, `hi_we`, `lo_we` while RUN: ignored; controller must stall.
- IDLE, `start` and `hi_we`/`lo_we` same edge: `start` wins, writes dropped.
- IDLE, `hi_we` and `lo_we` together: both written with `wdata`.
- mult: signed 32×32→64; multu: unsigned. HI=product[63:32], LO=product[31:0].
- div: signed, quotient truncates toward zero, remainder takes dividend's sign. LO=quotient, HI=remainder. divu: unsigned.
- Divide by zero (div or divu): LO=32'hFFFF_FFFF, HI=`a`.
- div 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- Operands latched at start; changes to `a`/`b` during RUN have no effect.
- Internal computation structure (combinational on latched operands or iterative) is free, provided commit timing below holds.

## Timing

- `start` sampled at edge k → `busy`=1 for cycles k..k+N-1 (N=`MULT_CYCLES`/`DIV_CYCLES`); HI/LO updated at edge k+N; `busy`=0 and `done`=1 in cycle after edge k+N.
- `busy` deasserts in the same cycle new HI/LO become visible; a new `start` is accepted at edge k+N+1 at the earliest.
- mthi/mtlo: HI/LO update at the sampling edge, visible next cycle.
- `reset` low during RUN: operation discarded at that edge, no commit, no `done`.
- `hi`, `lo` hold value at all times except commit/write/reset edges.

## Configuration

- `MULT_DIV_DIV_EN` defined: full behaviour above.
- Undefined: no divider logic. `start` with `md_op`=10/11 is ignored: stays IDLE, `busy`=0, no `done`, HI/LO unchanged. mult/multu/mthi/mtlo unaffected.

## Test plan

- Reset: hold `reset`=0 one edge after arbitrary writes → `hi`=0, `lo`=0, `busy`=0, `done`=0.
- mult a=32'hFFFF_FFFE (−2), b=3 → after 5 busy cycles HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA; multu same operands → HI=2, LO=32'hFFFF_FFFA; `done` pulses once.
- div a=−7 (32'hFFFF_FFF9), b=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF after 10 cycles; divu a=7, b=0 → LO=32'hFFFF_FFFF, HI=7.
- During RUN of mult 2×3, assert `start` (div) and `hi_we` with `wdata`=32'h1234 → ignored; final HI=0, LO=6.
- Idle `hi_we`=1, `lo_we`=1, `wdata`=32'hA5A5_A5A5 → both read A5A5_A5A5 next cycle; same with `start` asserted → writes dropped, op starts.
- Drop `reset` at cycle 3 of a div → `busy`=0, HI/LO=0, no `done`; with `MULT_DIV_DIV_EN` undefined, div `start` → `busy` never asserts.
